// File: rtl/flash_loader_arbiter.sv
// -----------------------------------------------------------------------------
// flash_loader_arbiter
//
// Shares one SPI master between the CPU port path and a hardware
// flash-to-memory loader. On start the loader takes the bus, issues a flash
// READ command with a 24-bit address, then streams LEN bytes into memory from
// DEST upward. While the loader owns the bus the CPU is stalled and any CPU
// strobe edge is held pending until the bus is returned.
//
// Optional feature macro: FLASH_LOADER_FAST_READ_EN
//   defined   : opcode CMD_FAST (0x0B) plus one dummy byte (0xFF) after A0
//   undefined : opcode CMD_READ (0x03), no dummy byte
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   start, abort        load request pulse / stop-after-current-byte level
//   base_addr, dest_addr, len   load parameters, sampled on start
//   busy, done          loader status
//   mem_addr, mem_data, mem_we, mem_rdy   memory write port (held until rdy)
//   cpu_wr, cpu_rd, cpu_din, cpu_cs_n, cpu_wait_n   CPU SPI port
//   flash_cs_n, sd_cs_force                          chip selects
//   spi_wr, spi_rd, spi_wdata, spi_rdata, spi_busy   SPI engine interface
// -----------------------------------------------------------------------------
module flash_loader_arbiter #(
    parameter logic [7:0] CMD_READ = 8'h03,
    parameter logic [7:0] CMD_FAST = 8'h0B,
    parameter int         LEN_W    = 16,
    parameter int         MEM_AW   = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [23:0]       base_addr,
    input  logic [MEM_AW-1:0] dest_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_we,
    input  logic              mem_rdy,
    input  logic              cpu_wr,
    input  logic              cpu_rd,
    input  logic [7:0]        cpu_din,
    input  logic              cpu_cs_n,
    output logic              cpu_wait_n,
    output logic              flash_cs_n,
    output logic              sd_cs_force,
    output logic              spi_wr,
    output logic              spi_rd,
    output logic [7:0]        spi_wdata,
    input  logic [7:0]        spi_rdata,
    input  logic              spi_busy
);

`ifdef FLASH_LOADER_FAST_READ_EN
    localparam logic FAST_EN = 1'b1;
`else
    localparam logic FAST_EN = 1'b0;
`endif

    localparam logic [7:0] OPCODE = FAST_EN ? CMD_FAST : CMD_READ;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ARB,
        S_CS_LO,
        S_CMD,
        S_A2,
        S_A1,
        S_A0,
        S_DUMMY,
        S_RDB,
        S_STORE,
        S_CS_HI,
        S_DONE
    } state_t;

    localparam state_t FIRST_DATA = FAST_EN ? S_DUMMY : S_RDB;

    state_t             state_reg, state_next;
    logic               phase_reg, phase_next;   // 0: pulse cycle, 1: wait for spi_busy low
    logic               abort_reg, abort_next;   // abort seen during this load
    logic [23:0]        base_reg, base_next;
    logic [MEM_AW-1:0]  dest_reg, dest_next;
    logic [LEN_W-1:0]   len_reg, len_next;
    logic [LEN_W-1:0]   count_reg, count_next;
    logic [7:0]         rdata_reg, rdata_next;
    logic               wr_pend_reg, wr_pend_next;
    logic [7:0]         wr_data_reg, wr_data_next;
    logic               rd_pend_reg, rd_pend_next;
    logic               pulse_d_reg;             // SPI pulse issued last cycle
    logic [1:0]         strb_d_reg;

    logic [1:0]         strb;
    logic [1:0]         strb_rise;
    logic               wr_rise;
    logic               rd_rise;
    logic               abort_now;
    logic [LEN_W-1:0]   count_inc;
    logic [7:0]         byte_tx;
    state_t             byte_seq;

    // Rising-edge detect of the CPU strobes: bit 0 = write, bit 1 = read.
    assign strb = {cpu_rd, cpu_wr};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_strb_edge
            assign strb_rise[gi] = strb[gi] & ~strb_d_reg[gi];
        end
    endgenerate

    assign wr_rise   = strb_rise[0];
    assign rd_rise   = strb_rise[1];
    assign abort_now = abort | abort_reg;
    assign count_inc = count_reg + LEN_W'(1);

    assign mem_addr  = dest_reg + MEM_AW'(count_reg);
    assign mem_data  = rdata_reg;

    // Transmit byte and successor state of each header byte step.
    always_comb begin
        byte_tx  = 8'hFF;
        byte_seq = S_CS_HI;
        case (state_reg)
            S_CMD:   begin byte_tx = OPCODE;          byte_seq = S_A2;       end
            S_A2:    begin byte_tx = base_reg[23:16]; byte_seq = S_A1;       end
            S_A1:    begin byte_tx = base_reg[15:8];  byte_seq = S_A0;       end
            S_A0:    begin byte_tx = base_reg[7:0];   byte_seq = FIRST_DATA; end
            S_DUMMY: begin byte_tx = 8'hFF;           byte_seq = S_RDB;      end
            default: begin byte_tx = 8'hFF;           byte_seq = S_CS_HI;    end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            phase_reg   <= 1'b0;
            abort_reg   <= 1'b0;
            base_reg    <= '0;
            dest_reg    <= '0;
            len_reg     <= '0;
            count_reg   <= '0;
            rdata_reg   <= '0;
            wr_pend_reg <= 1'b0;
            wr_data_reg <= '0;
            rd_pend_reg <= 1'b0;
            pulse_d_reg <= 1'b0;
            strb_d_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            phase_reg   <= phase_next;
            abort_reg   <= abort_next;
            base_reg    <= base_next;
            dest_reg    <= dest_next;
            len_reg     <= len_next;
            count_reg   <= count_next;
            rdata_reg   <= rdata_next;
            wr_pend_reg <= wr_pend_next;
            wr_data_reg <= wr_data_next;
            rd_pend_reg <= rd_pend_next;
            pulse_d_reg <= spi_wr | spi_rd;
            strb_d_reg  <= strb;
        end
    end

    always_comb begin
        state_next   = state_reg;
        phase_next   = phase_reg;
        abort_next   = abort_reg;
        base_next    = base_reg;
        dest_next    = dest_reg;
        len_next     = len_reg;
        count_next   = count_reg;
        rdata_next   = rdata_reg;
        // CPU edges are always captured; IDLE consumes them below.
        wr_pend_next = wr_pend_reg | wr_rise;
        wr_data_next = wr_rise ? cpu_din : wr_data_reg;
        rd_pend_next = rd_pend_reg | rd_rise;

        busy         = 1'b1;
        done         = 1'b0;
        mem_we       = 1'b0;
        spi_wr       = 1'b0;
        spi_rd       = 1'b0;
        spi_wdata    = 8'hFF;
        cpu_wait_n   = 1'b0;
        flash_cs_n   = 1'b1;
        sd_cs_force  = 1'b0;

        case (state_reg)
            S_IDLE: begin
                busy       = 1'b0;
                flash_cs_n = cpu_cs_n;
                cpu_wait_n = ~spi_busy;
                abort_next = 1'b0;
                phase_next = 1'b0;
                // A held-over request goes first; a fresh edge arriving in
                // the same cycle stays pending for the next one.
                if (wr_pend_reg) begin
                    spi_wr       = 1'b1;
                    spi_wdata    = wr_data_reg;
                    wr_pend_next = wr_rise;
                end else if (wr_rise) begin
                    spi_wr       = 1'b1;
                    spi_wdata    = cpu_din;
                    wr_pend_next = 1'b0;
                end else if (rd_pend_reg) begin
                    spi_rd       = 1'b1;
                    rd_pend_next = rd_rise;
                end else if (rd_rise) begin
                    spi_rd       = 1'b1;
                    rd_pend_next = 1'b0;
                end
                if (start) begin
                    base_next  = base_addr;
                    dest_next  = dest_addr;
                    len_next   = len;
                    count_next = '0;
                    state_next = (len == '0) ? S_DONE : S_ARB;
                end
            end

            S_ARB: begin
                // pulse_d covers a CPU pulse issued just before the engine
                // has raised spi_busy.
                if (!spi_busy && !pulse_d_reg) begin
                    state_next = S_CS_LO;
                end
            end

            S_CS_LO: begin
                flash_cs_n  = 1'b0;
                sd_cs_force = 1'b1;
                phase_next  = 1'b0;
                state_next  = S_CMD;
            end

            S_CMD, S_A2, S_A1, S_A0, S_DUMMY, S_RDB: begin
                flash_cs_n  = 1'b0;
                sd_cs_force = 1'b1;
                spi_wdata   = byte_tx;
                if (abort) begin
                    abort_next = 1'b1;
                end
                if (!phase_reg) begin
                    if (state_reg == S_RDB) begin
                        spi_rd = 1'b1;
                    end else begin
                        spi_wr = 1'b1;
                    end
                    phase_next = 1'b1;
                end else if (!spi_busy) begin
                    phase_next = 1'b0;
                    if (state_reg == S_RDB) begin
                        // A received byte is always stored, even on abort.
                        rdata_next = spi_rdata;
                        state_next = S_STORE;
                    end else begin
                        state_next = abort_now ? S_CS_HI : byte_seq;
                    end
                end
            end

            S_STORE: begin
                flash_cs_n  = 1'b0;
                sd_cs_force = 1'b1;
                mem_we      = 1'b1;
                if (abort) begin
                    abort_next = 1'b1;
                end
                if (mem_rdy) begin
                    count_next = count_inc;
                    phase_next = 1'b0;
                    state_next = (count_inc == len_reg || abort_now) ? S_CS_HI : S_RDB;
                end
            end

            S_CS_HI: begin
                sd_cs_force = 1'b1;
                state_next  = S_DONE;
            end

            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_flash_loader_arbiter.sv
module tb_flash_loader_arbiter;

    localparam int MEM_AW = 19;
    localparam int LEN_W  = 16;
`ifdef FLASH_LOADER_FAST_READ_EN
    localparam int         HDR = 5;
    localparam logic [7:0] OPC = 8'h0B;
`else
    localparam int         HDR = 4;
    localparam logic [7:0] OPC = 8'h03;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [23:0]       base_addr;
    logic [MEM_AW-1:0] dest_addr;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              done;
    logic [MEM_AW-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              mem_we;
    logic              mem_rdy;
    logic              cpu_wr;
    logic              cpu_rd;
    logic [7:0]        cpu_din;
    logic              cpu_cs_n;
    logic              cpu_wait_n;
    logic              flash_cs_n;
    logic              sd_cs_force;
    logic              spi_wr;
    logic              spi_rd;
    logic [7:0]        spi_wdata;
    logic [7:0]        spi_rdata;
    logic              spi_busy;

    always #5 clk = ~clk;

    flash_loader_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .base_addr  (base_addr),
        .dest_addr  (dest_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_we     (mem_we),
        .mem_rdy    (mem_rdy),
        .cpu_wr     (cpu_wr),
        .cpu_rd     (cpu_rd),
        .cpu_din    (cpu_din),
        .cpu_cs_n   (cpu_cs_n),
        .cpu_wait_n (cpu_wait_n),
        .flash_cs_n (flash_cs_n),
        .sd_cs_force(sd_cs_force),
        .spi_wr     (spi_wr),
        .spi_rd     (spi_rd),
        .spi_wdata  (spi_wdata),
        .spi_rdata  (spi_rdata),
        .spi_busy   (spi_busy)
    );

    // SPI engine + flash model: each exchange keeps spi_busy high 3 cycles.
    // Flash returns 0xFF during the header, then 0xA0, 0xA1, ...
    int                busy_cnt;
    int                flash_idx;
    int                n_spi_wr;
    int                n_spi_rd;
    int                n_mem_wr;
    int                n_done;
    int                n_cs_low;
    logic [7:0]        mosi_q[$];
    logic [MEM_AW-1:0] waddr_q[$];
    logic [7:0]        wdata_q[$];

    assign spi_busy = (busy_cnt != 0);

    always @(posedge clk) begin
        if (rst) begin
            busy_cnt  <= 0;
            flash_idx <= 0;
            spi_rdata <= 8'hFF;
        end else begin
            if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
            if (flash_cs_n) flash_idx <= 0;
            if (spi_wr || spi_rd) begin
                busy_cnt <= 3;
                if (spi_wr) begin
                    n_spi_wr <= n_spi_wr + 1;
                    mosi_q.push_back(spi_wdata);
                    $display("%0t spi_wr %02h cs_n=%0b", $time, spi_wdata, flash_cs_n);
                end else begin
                    n_spi_rd <= n_spi_rd + 1;
                    $display("%0t spi_rd cs_n=%0b", $time, flash_cs_n);
                end
                if (!flash_cs_n) begin
                    flash_idx <= flash_idx + 1;
                    spi_rdata <= (flash_idx >= HDR) ? 8'hA0 + 8'(flash_idx - HDR) : 8'hFF;
                end
            end
            if (mem_we && mem_rdy) begin
                n_mem_wr <= n_mem_wr + 1;
                waddr_q.push_back(mem_addr);
                wdata_q.push_back(mem_data);
                $display("%0t mem_wr addr=%05h data=%02h", $time, mem_addr, mem_data);
            end
            if (done) begin
                n_done <= n_done + 1;
                $display("%0t done", $time);
            end
            if (!flash_cs_n) n_cs_low <= n_cs_low + 1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [23:0] b, input logic [MEM_AW-1:0] d, input logic [LEN_W-1:0] l);
        @(negedge clk);
        base_addr = b;
        dest_addr = d;
        len       = l;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    int s_wr, s_rd, s_mem, s_done, s_cs, s_mq;
    logic [MEM_AW-1:0] held_addr;
    logic [7:0]        held_data;
    bit                found;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        base_addr = '0; dest_addr = '0; len = '0;
        mem_rdy = 1'b1; cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_din = '0; cpu_cs_n = 1'b1;

        // ---- reset state ----
        repeat (2) @(negedge clk);
        check("rst_busy",       32'(busy),        32'd0);
        check("rst_done",       32'(done),        32'd0);
        check("rst_mem_we",     32'(mem_we),      32'd0);
        check("rst_spi_wr",     32'(spi_wr),      32'd0);
        check("rst_spi_rd",     32'(spi_rd),      32'd0);
        check("rst_cpu_wait_n", 32'(cpu_wait_n),  32'd1);
        check("rst_sd_force",   32'(sd_cs_force), 32'd0);
        cpu_cs_n = 1'b0; #1;
        check("rst_cs_follow0", 32'(flash_cs_n),  32'd0);
        cpu_cs_n = 1'b1; #1;
        check("rst_cs_follow1", 32'(flash_cs_n),  32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // ---- len=3 load, destination wraps at top of memory ----
        s_wr = n_spi_wr; s_rd = n_spi_rd; s_mem = n_mem_wr; s_done = n_done; s_mq = mosi_q.size();
        do_start(24'h012345, 19'h7FFFF, 16'd3);
        check("l3_busy", 32'(busy), 32'd1);
        wait_done(300, "l3_done_timeout");
        @(negedge clk);
        check("l3_busy_after", 32'(busy), 32'd0);
        check("l3_n_wr",   32'(n_spi_wr - s_wr), 32'(HDR));
        check("l3_n_rd",   32'(n_spi_rd - s_rd), 32'd3);
        check("l3_opcode", 32'(mosi_q[s_mq + 0]), 32'(OPC));
        check("l3_a2",     32'(mosi_q[s_mq + 1]), 32'h01);
        check("l3_a1",     32'(mosi_q[s_mq + 2]), 32'h23);
        check("l3_a0",     32'(mosi_q[s_mq + 3]), 32'h45);
`ifdef FLASH_LOADER_FAST_READ_EN
        check("l3_dummy",  32'(mosi_q[s_mq + 4]), 32'hFF);
`endif
        check("l3_n_mem",  32'(n_mem_wr - s_mem), 32'd3);
        check("l3_addr0",  32'(waddr_q[s_mem + 0]), 32'h7FFFF);
        check("l3_addr1",  32'(waddr_q[s_mem + 1]), 32'h00000);
        check("l3_addr2",  32'(waddr_q[s_mem + 2]), 32'h00001);
        check("l3_data0",  32'(wdata_q[s_mem + 0]), 32'hA0);
        check("l3_data1",  32'(wdata_q[s_mem + 1]), 32'hA1);
        check("l3_data2",  32'(wdata_q[s_mem + 2]), 32'hA2);
        check("l3_n_done", 32'(n_done - s_done), 32'd1);
        check("l3_cs_high", 32'(flash_cs_n), 32'd1);
        check("l3_sd_rel", 32'(sd_cs_force), 32'd0);
        repeat (5) @(negedge clk);

        // ---- len=0: immediate done, bus untouched ----
        s_wr = n_spi_wr; s_rd = n_spi_rd; s_done = n_done; s_cs = n_cs_low;
        do_start(24'h000100, 19'h00010, 16'd0);
        check("l0_done_pulse", 32'(done), 32'd1);
        @(negedge clk);
        check("l0_done_low",  32'(done), 32'd0);
        check("l0_busy",      32'(busy), 32'd0);
        check("l0_n_done",    32'(n_done - s_done), 32'd1);
        check("l0_cs_low",    32'(n_cs_low - s_cs), 32'd0);
        check("l0_n_pulses",  32'((n_spi_wr - s_wr) + (n_spi_rd - s_rd)), 32'd0);

        // ---- CPU write edge during load is deferred until after DONE ----
        s_wr = n_spi_wr; s_rd = n_spi_rd; s_mem = n_mem_wr; s_mq = mosi_q.size();
        do_start(24'hABCDEF, 19'h00200, 16'd2);
        repeat (3) @(negedge clk);
        cpu_din = 8'h5A;
        cpu_wr  = 1'b1;
        #1;
        check("cpu_stall", 32'(cpu_wait_n), 32'd0);
        wait_done(300, "cpu_done_timeout");
        repeat (6) @(negedge clk);
        cpu_wr = 1'b0;
        check("cpu_n_wr",   32'(n_spi_wr - s_wr), 32'(HDR + 1));
        check("cpu_last",   32'(mosi_q[s_mq + HDR]), 32'h5A);
        check("cpu_n_rd",   32'(n_spi_rd - s_rd), 32'd2);
        check("cpu_n_mem",  32'(n_mem_wr - s_mem), 32'd2);
        check("cpu_wait_rel", 32'(cpu_wait_n), 32'd1);
        repeat (3) @(negedge clk);

        // ---- abort during the 2nd data byte of a len=100 load ----
        s_rd = n_spi_rd; s_mem = n_mem_wr; s_done = n_done;
        do_start(24'h000000, 19'h01000, 16'd100);
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (n_spi_rd - s_rd == 2) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("ab_reach_rdb2", 32'(found), 32'd1);
        abort = 1'b1;
        wait_done(300, "ab_done_timeout");
        abort = 1'b0;
        @(negedge clk);
        check("ab_n_mem",   32'(n_mem_wr - s_mem), 32'd2);
        check("ab_n_rd",    32'(n_spi_rd - s_rd), 32'd2);
        check("ab_data1",   32'(wdata_q[s_mem + 1]), 32'hA1);
        check("ab_cs_high", 32'(flash_cs_n), 32'd1);
        check("ab_n_done",  32'(n_done - s_done), 32'd1);
        repeat (3) @(negedge clk);

        // ---- memory stall: write held stable, no SPI activity ----
        mem_rdy = 1'b0;
        s_mem = n_mem_wr;
        do_start(24'h000040, 19'h00100, 16'd2);
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (mem_we === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("st_mem_we_seen", 32'(found), 32'd1);
        check("st_addr0", 32'(mem_addr), 32'h00100);
        check("st_data0", 32'(mem_data), 32'hA0);
        held_addr = mem_addr;
        held_data = mem_data;
        s_wr = n_spi_wr; s_rd = n_spi_rd;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("st_we_hold",   32'(mem_we),   32'd1);
            check("st_addr_hold", 32'(mem_addr), 32'(held_addr));
            check("st_data_hold", 32'(mem_data), 32'(held_data));
        end
        check("st_no_spi", 32'((n_spi_wr - s_wr) + (n_spi_rd - s_rd)), 32'd0);
        mem_rdy = 1'b1;
        wait_done(300, "st_done_timeout");
        @(negedge clk);
        check("st_n_mem", 32'(n_mem_wr - s_mem), 32'd2);
        check("st_data1", 32'(wdata_q[s_mem + 1]), 32'hA1);
        repeat (3) @(negedge clk);

        // ---- asynchronous reset in the middle of a load ----
        do_start(24'h000000, 19'h00000, 16'd10);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (flash_cs_n === 1'b0) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rm_cs_low_seen", 32'(found), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rm_cs_high", 32'(flash_cs_n),  32'd1);
        check("rm_busy",    32'(busy),        32'd0);
        check("rm_mem_we",  32'(mem_we),      32'd0);
        check("rm_sd",      32'(sd_cs_force), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
